// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: FSM state encodings, data-bit count, line levels
// and the parity-select constant. The transmitter and the receiver both use it.
// Optional build macro used by the users of this package: UART_TX_PARITY_EN.
package uart_defs_pkg;

  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_LINE_IDLE   = 1'b1;  // mark level; also the stop-bit level
  localparam logic UART_START_LEVEL = 1'b0;  // space level of the start bit
  localparam logic UART_PARITY_SEL  = 1'b0;  // 0: even parity, 1: odd parity

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART link.
// Counts 0..p_CLKs_PB-1 and wraps; bit_tick is high during the last count of
// each bit period. The count is held at zero while clear is high, so the first
// period after clear is released is a full p_CLKs_PB cycles.
// Ports:
//   i_Clk     in  system clock, rising edge
//   i_Rst     in  synchronous, active-high reset
//   clear     in  synchronous counter clear
//   bit_tick  out one-cycle pulse on the last count of a bit period
module uart_baud_gen #(
  parameter int p_CLKs_PB = 217
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int               CNT_W    = $clog2(p_CLKs_PB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(p_CLKs_PB - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_Clk) begin
    if (i_Rst || clear) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = !clear && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per accepted request, 8N1, LSB first, idle high.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after
// the data bits (frame becomes 11 bit periods).
// Ports:
//   i_Clk        in   system clock, rising edge
//   i_Rst        in   synchronous, active-high reset
//   i_Tx_DV      in   request strobe, accepted only while o_Tx_Ready=1
//   i_Tx_Byte    in   byte to send, sampled in the accepting cycle
//   o_Tx_Serial  out  registered UART line
//   o_Tx_Ready   out  idle and able to accept a request
//   o_Tx_Active  out  frame in progress
//   o_Tx_Done    out  one-cycle pulse after the stop bit
module uart_tx
  import uart_defs_pkg::*;
#(
  parameter int p_CLKs_PB = 217
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst,
  input  logic                      i_Tx_DV,
  input  logic [UART_DATA_BITS-1:0] i_Tx_Byte,
  output logic                      o_Tx_Serial,
  output logic                      o_Tx_Ready,
  output logic                      o_Tx_Active,
  output logic                      o_Tx_Done
);

  localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

  uart_state_t               state;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [2:0]                bit_idx;
  logic                      bit_tick;
  logic                      load;
  logic                      shift;
`ifdef UART_TX_PARITY_EN
  logic                      parity_acc;
`endif

  // The baud timer sits at zero while idle, so START always lasts a full period.
  uart_baud_gen #(
    .p_CLKs_PB (p_CLKs_PB)
  ) u_baud_gen (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .clear    (state == ST_IDLE),
    .bit_tick (bit_tick)
  );

  assign load  = (state == ST_IDLE) && i_Tx_DV;
  assign shift = (state == ST_DATA) && bit_tick && (bit_idx != LAST_IDX);

  // Data register carries no reset; it is only observed after a load.
  always_ff @(posedge i_Clk) begin
    if (load) begin
      shift_reg <= i_Tx_Byte;
    end else if (shift) begin
      shift_reg <= {1'b0, shift_reg[UART_DATA_BITS-1:1]};
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state       <= ST_IDLE;
      bit_idx     <= '0;
      o_Tx_Serial <= UART_LINE_IDLE;
      o_Tx_Ready  <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_acc  <= 1'b0;
`endif
    end else begin
      o_Tx_Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_Tx_Serial <= UART_LINE_IDLE;
          if (i_Tx_DV) begin
            bit_idx     <= '0;
            o_Tx_Serial <= UART_START_LEVEL;
            o_Tx_Ready  <= 1'b0;
            o_Tx_Active <= 1'b1;
            state       <= ST_START;
`ifdef UART_TX_PARITY_EN
            parity_acc  <= 1'b0;
`endif
          end
        end

        ST_START: begin
          if (bit_tick) begin
            o_Tx_Serial <= shift_reg[0];
            state       <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (bit_tick) begin
`ifdef UART_TX_PARITY_EN
            parity_acc <= parity_acc ^ shift_reg[0];
`endif
            if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              o_Tx_Serial <= parity_acc ^ shift_reg[0] ^ UART_PARITY_SEL;
              state       <= ST_PARITY;
`else
              o_Tx_Serial <= UART_LINE_IDLE;
              state       <= ST_STOP;
`endif
            end else begin
              // shift_reg[1] becomes shift_reg[0] on this same edge.
              bit_idx     <= bit_idx + 3'd1;
              o_Tx_Serial <= shift_reg[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            o_Tx_Serial <= UART_LINE_IDLE;
            state       <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (bit_tick) begin
            o_Tx_Serial <= UART_LINE_IDLE;
            o_Tx_Ready  <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        default: begin
          bit_idx     <= '0;
          o_Tx_Serial <= UART_LINE_IDLE;
          o_Tx_Ready  <= 1'b1;
          o_Tx_Active <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed sequence with a serial-decoding monitor that
// pops expected bytes from a scoreboard queue. Honours UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int P  = 8;
  localparam int P2 = 217;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, dv, tx_serial, ready, active, done;
  logic [7:0] tx_byte;
  logic       rst2, dv2, tx_serial2, ready2, active2, done2;
  logic [7:0] tx_byte2;

  int         total = 0;
  int         bad = 0;
  int         frames_seen = 0;
  int         frames_sent = 0;
  bit         mon_en = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_d;
  logic [7:0] mon_exp;
  logic       obs_wave[NBITS*P];

  always #5 clk = ~clk;

  uart_tx #(.p_CLKs_PB(P)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Tx_DV(dv), .i_Tx_Byte(tx_byte),
    .o_Tx_Serial(tx_serial), .o_Tx_Ready(ready), .o_Tx_Active(active), .o_Tx_Done(done)
  );

  uart_tx #(.p_CLKs_PB(P2)) dut217 (
    .i_Clk(clk), .i_Rst(rst2), .i_Tx_DV(dv2), .i_Tx_Byte(tx_byte2),
    .o_Tx_Serial(tx_serial2), .o_Tx_Ready(ready2), .o_Tx_Active(active2), .o_Tx_Done(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Reference line level for interval i (0-based) of a frame with p clocks per bit.
  function automatic logic exp_level(input logic [7:0] b, input int i, input int p);
    int bitn;
    bitn = i / p;
    if (bitn == 0) return 1'b0;
    if (bitn <= 8) return b[bitn-1];
    if (PAR && bitn == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic send(input logic [7:0] b, input bit track);
    int guard;
    guard = 0;
    while (ready !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready", ready, 1);
    dv = 1'b1;
    tx_byte = b;
    @(posedge clk);
    if (track) begin
      exp_q.push_back(b);
      frames_sent++;
    end
    #1;
    dv = 1'b0;
    tx_byte = 8'($urandom);
  endtask

  // Called right after the accepting edge; returns in the Done cycle.
  task automatic capture(input logic [7:0] b, input string tag);
    int wave_err;
    int ctl_err;
    wave_err = 0;
    ctl_err = 0;
    for (int i = 0; i < NBITS*P; i++) begin
      @(negedge clk);
      obs_wave[i] = tx_serial;
      if (tx_serial !== exp_level(b, i, P)) wave_err++;
      if (active !== 1'b1 || ready !== 1'b0 || done !== 1'b0) ctl_err++;
    end
    check({tag, "_wave_err"}, wave_err, 0);
    check({tag, "_ctl_err"}, ctl_err, 0);
    @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_ready_at_done"}, ready, 1);
    check({tag, "_active_at_done"}, active, 0);
  endtask

  // Serial decoder: samples mid-bit and compares against the scoreboard.
  always begin
    @(negedge clk);
    if (mon_en && tx_serial === 1'b0) begin
      repeat (P/2) @(negedge clk);
      check("mon_start", tx_serial, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (P) @(negedge clk);
        mon_d[i] = tx_serial;
      end
`ifdef UART_TX_PARITY_EN
      repeat (P) @(negedge clk);
      check("mon_parity", tx_serial, ^mon_d);
`endif
      repeat (P) @(negedge clk);
      check("mon_stop", tx_serial, 1);
      frames_seen++;
      mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check("mon_byte", mon_d, mon_exp);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int match[NBITS];
    rst = 1'b1; dv = 1'b0; tx_byte = 8'h00;
    rst2 = 1'b1; dv2 = 1'b0; tx_byte2 = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_line", tx_serial, 1);
    check("rst_ready", ready, 1);
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    check("rst2_line", tx_serial2, 1);
    check("rst2_ready", ready2, 1);
    rst = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // 1: single byte, waveform and Done timing
    send(8'h55, 1'b1);
    capture(8'h55, "t1");
    @(negedge clk);
    check("t1_done_single", done, 0);
    check("t1_idle_line", tx_serial, 1);

    // 2: back-to-back, second DV in the Done cycle
    send(8'hA5, 1'b1);
    capture(8'hA5, "t2a");
    send(8'h3C, 1'b1);
    capture(8'h3C, "t2b");

    // 3: DV while busy is ignored
    send(8'hFF, 1'b1);
    repeat (30) @(negedge clk);
    check("t3_busy_ready", ready, 0);
    dv = 1'b1;
    tx_byte = 8'h00;
    @(posedge clk);
    #1;
    dv = 1'b0;
    n = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    check("t3_done_count", n, 1);
    check("t3_idle_line", tx_serial, 1);
    check("t3_idle_ready", ready, 1);

    // 4: reset during data bit 3
    mon_en = 1'b0;
    send(8'hC3, 1'b0);
    repeat (35) @(negedge clk);
    check("t4_active_pre", active, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t4_line", tx_serial, 1);
    check("t4_ready", ready, 1);
    check("t4_active", active, 0);
    check("t4_done", done, 0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1 || tx_serial !== 1'b1) n++;
    end
    check("t4_quiet", n, 0);
    mon_en = 1'b1;
    send(8'h81, 1'b1);
    capture(8'h81, "t4");

`ifdef UART_TX_PARITY_EN
    // 5: parity bit
    send(8'h07, 1'b1);
    capture(8'h07, "t5a");
    check("t5a_parity", obs_wave[9*P + P/2], 1);
    send(8'h03, 1'b1);
    capture(8'h03, "t5b");
    check("t5b_parity", obs_wave[9*P + P/2], 0);
`endif

    // 6: 217 clocks per bit, every bit width measured
    n = 0;
    while (ready2 !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("t6_ready", ready2, 1);
    dv2 = 1'b1;
    tx_byte2 = 8'h4B;
    @(posedge clk);
    #1;
    dv2 = 1'b0;
    tx_byte2 = 8'h00;
    for (int b = 0; b < NBITS; b++) match[b] = 0;
    for (int i = 0; i < NBITS*P2; i++) begin
      @(negedge clk);
      if (tx_serial2 === exp_level(8'h4B, i, P2)) match[i / P2]++;
    end
    for (int b = 0; b < NBITS; b++) begin
      check($sformatf("t6_bit%0d_width", b), match[b], P2);
    end
    @(negedge clk);
    check("t6_done", done2, 1);

    repeat (20) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    check("sb_frames", frames_seen, frames_sent);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
